// File: rtl/tri_raster_pkg.sv
// tri_raster_pkg: FSM states, vertex type and edge-function width helper shared by the triangle rasteriser.
package tri_raster_pkg;
  localparam int MAX_W = 12;
  typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, SETUP, SCAN, DONE} state_t;
  typedef struct packed {
    logic [MAX_W-1:0] x;
    logic [MAX_W-1:0] y;
  } vertex_t;
  function automatic int edge_w(input int cw);
    return 2 * cw + 3;
  endfunction
endpackage

// File: rtl/tri_edge_eval.sv
// tri_edge_eval: three signed edge functions of a candidate point and a winding-independent inside flag.
module tri_edge_eval
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [COORD_W-1:0] i_x2,
  input  logic [COORD_W-1:0] i_y2,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  output logic               o_inside
);
  localparam int EW = edge_w(COORD_W);
  logic signed [EW-1:0] w_e0, w_e1, w_e2;
  logic w_nonneg, w_nonpos;
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [COORD_W-1:0] xa, ya, xb, yb, px, py
  );
    logic signed [EW-1:0] dx, dy, ex, ey;
    dx = $signed(EW'(px)) - $signed(EW'(xa));
    dy = $signed(EW'(py)) - $signed(EW'(ya));
    ex = $signed(EW'(xb)) - $signed(EW'(xa));
    ey = $signed(EW'(yb)) - $signed(EW'(ya));
    return dx * ey - dy * ex;
  endfunction
  assign w_e0 = edge_fn(i_x0, i_y0, i_x1, i_y1, i_px, i_py);
  assign w_e1 = edge_fn(i_x1, i_y1, i_x2, i_y2, i_px, i_py);
  assign w_e2 = edge_fn(i_x2, i_y2, i_x0, i_y0, i_px, i_py);
  assign w_nonneg = !w_e0[EW-1] && !w_e1[EW-1] && !w_e2[EW-1];
  assign w_nonpos = (w_e0[EW-1] || w_e0 == '0) && (w_e1[EW-1] || w_e1 == '0) &&
                    (w_e2[EW-1] || w_e2 == '0);
  assign o_inside = w_nonneg || w_nonpos;
endmodule

// File: rtl/triangle_raster_stream.sv
// triangle_raster_stream: captures three vertices, scans their bounding box and streams inside points.
// Optional point counter output pcnt enabled by defining TRI_POINT_COUNT_EN.
module triangle_raster_stream
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               nt,
  input  logic [COORD_W-1:0] xi,
  input  logic [COORD_W-1:0] yi,
  input  logic               po_ready,
  output logic               busy,
  output logic               po,
  output logic [COORD_W-1:0] xo,
  output logic [COORD_W-1:0] yo,
  output logic               done
`ifdef TRI_POINT_COUNT_EN
  ,
  output logic [2*COORD_W:0] pcnt
`endif
);
  state_t r_state, w_next;
  vertex_t r_v0, r_v1, r_v2, r_hi, r_cur, w_lo, w_hi, w_in;
  logic [MAX_W-1:0] r_xmin;
  logic r_end, r_po;
  logic [COORD_W-1:0] r_xo, r_yo;
  logic w_inside, w_drain, w_adv;
  function automatic logic [MAX_W-1:0] min3(input logic [MAX_W-1:0] a, b, c);
    return (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
  endfunction
  function automatic logic [MAX_W-1:0] max3(input logic [MAX_W-1:0] a, b, c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  assign w_in = '{x: MAX_W'(xi), y: MAX_W'(yi)};
  assign w_lo = '{x: min3(r_v0.x, r_v1.x, r_v2.x), y: min3(r_v0.y, r_v1.y, r_v2.y)};
  assign w_hi = '{x: max3(r_v0.x, r_v1.x, r_v2.x), y: max3(r_v0.y, r_v1.y, r_v2.y)};
  tri_edge_eval #(.COORD_W(COORD_W)) u_edge (
    .i_x0    (r_v0.x[COORD_W-1:0]),
    .i_y0    (r_v0.y[COORD_W-1:0]),
    .i_x1    (r_v1.x[COORD_W-1:0]),
    .i_y1    (r_v1.y[COORD_W-1:0]),
    .i_x2    (r_v2.x[COORD_W-1:0]),
    .i_y2    (r_v2.y[COORD_W-1:0]),
    .i_px    (r_cur.x[COORD_W-1:0]),
    .i_py    (r_cur.y[COORD_W-1:0]),
    .o_inside(w_inside)
  );
  // a candidate is consumed only when the output register is empty or draining this cycle
  assign w_drain = r_po && po_ready;
  assign w_adv   = (r_state == SCAN) && !r_end && (!r_po || po_ready);
  always_ff @(posedge clk) r_state <= reset ? w_next : IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = nt ? LOAD1 : IDLE;
      LOAD1:   w_next = LOAD2;
      LOAD2:   w_next = SETUP;
      SETUP:   w_next = SCAN;
      SCAN:    w_next = (r_end && (!r_po || po_ready)) ? DONE : SCAN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    busy = (r_state == LOAD1) || (r_state == LOAD2) || (r_state == SETUP) || (r_state == SCAN);
    done = (r_state == DONE);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v0   <= '0;
      r_v1   <= '0;
      r_v2   <= '0;
      r_hi   <= '0;
      r_cur  <= '0;
      r_xmin <= '0;
      r_end  <= 1'b0;
      r_po   <= 1'b0;
      r_xo   <= '0;
      r_yo   <= '0;
    end else begin
      if (r_state == IDLE && nt) r_v0 <= w_in;
      if (r_state == LOAD1) r_v1 <= w_in;
      if (r_state == LOAD2) r_v2 <= w_in;
      if (r_state == SETUP) begin
        r_xmin <= w_lo.x;
        r_hi   <= w_hi;
        r_cur  <= w_lo;
        r_end  <= 1'b0;
      end
      if (w_drain) r_po <= 1'b0;
      if (w_adv) begin
        if (w_inside) begin
          r_po <= 1'b1;
          r_xo <= r_cur.x[COORD_W-1:0];
          r_yo <= r_cur.y[COORD_W-1:0];
        end
        // compare before incrementing so an all-ones coordinate never wraps
        if (r_cur.x == r_hi.x) begin
          r_cur.x <= r_xmin;
          if (r_cur.y == r_hi.y) r_end <= 1'b1;
          else r_cur.y <= r_cur.y + 1'b1;
        end else begin
          r_cur.x <= r_cur.x + 1'b1;
        end
      end
    end
  end
  assign po = r_po;
  assign xo = r_xo;
  assign yo = r_yo;
`ifdef TRI_POINT_COUNT_EN
  logic [2*COORD_W:0] r_pcnt;
  always_ff @(posedge clk) begin
    if (!reset || (r_state == IDLE && nt)) r_pcnt <= '0;
    else if (w_drain) r_pcnt <= r_pcnt + 1'b1;
  end
  assign pcnt = r_pcnt;
`endif
endmodule

// File: tb/tb_triangle_raster_stream.sv
// tb_triangle_raster_stream: randomized and directed stream checks against a lattice-point reference model.
module tb_triangle_raster_stream;
  localparam int W = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic nt = 1'b0;
  logic po_ready = 1'b1;
  logic [W-1:0] xi = '0;
  logic [W-1:0] yi = '0;
  logic busy, po, done;
  logic [W-1:0] xo, yo;
`ifdef TRI_POINT_COUNT_EN
  logic [2*W:0] pcnt;
`endif
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  triangle_raster_stream #(.COORD_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .nt      (nt),
    .xi      (xi),
    .yi      (yi),
    .po_ready(po_ready),
    .busy    (busy),
    .po      (po),
    .xo      (xo),
    .yo      (yo),
    .done    (done)
`ifdef TRI_POINT_COUNT_EN
    ,
    .pcnt    (pcnt)
`endif
  );
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int pt(input int x, input int y);
    return x * 16 + y;
  endfunction
  function automatic int mn(input int a, input int b, input int c);
    return (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
  endfunction
  function automatic int mx(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  function automatic int edge_val(input int xa, ya, xb, yb, x, y);
    return (x - xa) * (yb - ya) - (y - ya) * (xb - xa);
  endfunction
  task automatic build_exp(input int x0, y0, x1, y1, x2, y2);
    int e0, e1, e2;
    exp_q.delete();
    for (int y = mn(y0, y1, y2); y <= mx(y0, y1, y2); y++)
      for (int x = mn(x0, x1, x2); x <= mx(x0, x1, x2); x++) begin
        e0 = edge_val(x0, y0, x1, y1, x, y);
        e1 = edge_val(x1, y1, x2, y2, x, y);
        e2 = edge_val(x2, y2, x0, y0, x, y);
        if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
          exp_q.push_back(pt(x, y));
      end
  endtask
  // mode 0: always ready, 1: random ready, 2: stall the second point for 4 cycles
  task automatic run_tri(input int x0, y0, x1, y1, x2, y2, input int mode, input bit noise);
    int n_exp, n, stall, px, py;
    bit got, prev;
    build_exp(x0, y0, x1, y1, x2, y2);
    n_exp = exp_q.size();
    n = 0;
    stall = 0;
    got = 1'b0;
    prev = 1'b0;
    px = 0;
    py = 0;
    @(negedge clk);
    nt = 1'b1;
    xi = W'(x0);
    yi = W'(y0);
    po_ready = 1'b1;
    @(negedge clk);
    nt = 1'b0;
    xi = W'(x1);
    yi = W'(y1);
    @(negedge clk);
    xi = W'(x2);
    yi = W'(y2);
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      nt = noise && (c == 4 || c == 5);
      xi = W'($urandom);
      yi = W'($urandom);
      if (prev) begin
        check("hold_po", int'(po), 1);
        check("hold_xy", pt(int'(xo), int'(yo)), pt(px, py));
      end
      if (done) begin
        got = 1'b1;
        check("done_busy", int'(busy), 0);
        check("npoints", n, n_exp);
      end else begin
        check("busy", int'(busy), 1);
        if (mode == 0) po_ready = 1'b1;
        else if (mode == 1) po_ready = 1'($urandom_range(0, 1));
        else po_ready = !(po && n == 1 && stall < 4);
        if (mode == 2 && po && !po_ready) stall++;
        if (po && po_ready) begin
          check("point", pt(int'(xo), int'(yo)), exp_q.size() > 0 ? exp_q.pop_front() : -1);
          n++;
        end
        prev = po && !po_ready;
        px = int'(xo);
        py = int'(yo);
      end
    end
    nt = 1'b0;
    po_ready = 1'b1;
    check("timeout", int'(got), 1);
    if (mode == 2) check("stall_cycles", stall, 4);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("po_after_done", int'(po), 0);
`ifdef TRI_POINT_COUNT_EN
    check("pcnt", int'(pcnt), n_exp);
`endif
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_po", int'(po), 0);
    check("rst_done", int'(done), 0);
    check("rst_xy", pt(int'(xo), int'(yo)), 0);
    reset = 1'b1;
    run_tri(0, 0, 2, 0, 0, 2, 0, 1'b0);
    run_tri(0, 0, 0, 2, 2, 0, 0, 1'b0);
    run_tri(0, 0, 2, 0, 0, 2, 2, 1'b0);
    run_tri(1, 1, 3, 3, 5, 5, 0, 1'b0);
    run_tri(7, 7, 7, 7, 7, 7, 0, 1'b0);
    run_tri(0, 0, 2, 0, 0, 2, 0, 1'b1);
    run_tri(7, 0, 0, 7, 7, 7, 1, 1'b0);
    for (int t = 0; t < 10; t++)
      run_tri($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1, 1'b0);
    @(negedge clk);
    nt = 1'b1;
    xi = 3'd0;
    yi = 3'd0;
    po_ready = 1'b1;
    @(negedge clk);
    nt = 1'b0;
    xi = 3'd7;
    yi = 3'd0;
    @(negedge clk);
    xi = 3'd0;
    yi = 3'd7;
    repeat (6) @(negedge clk);
    check("midscan_po", int'(po), 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_po", int'(po), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_xy", pt(int'(xo), int'(yo)), 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_abort_po", int'(po), 0);
      check("post_abort_busy", int'(busy), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
